sr_prog_scheduler: RTL and testbench

//  Arbitrates and sequences serial programming of the ASIC's two configuration shift registers:

---
 rtl/sr_prog_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sr_prog_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_prog_scheduler.sv
// sr_prog_scheduler: round-robin arbiter and serial shifter for the dynamic and
// static configuration shift registers. A granted image is driven MSB-first on
// MOSI with SCLK idling low; SEL marks a dynamic frame.
module sr_prog_scheduler #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int CLK_DIV    = 4,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int INIT_WAIT  = 60
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_en,
  input  logic                  dyn_req,
  input  logic [SIZESRDYN-1:0]  dyn_data,
  output logic                  dyn_ack,
  input  logic                  stat_req,
  input  logic [SIZESRSTAT-1:0] stat_data,
  output logic                  stat_ack,
  output logic                  SEL,
  output logic                  MOSI,
  output logic                  SCLK,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_W    = $clog2(SIZESRSTAT + 1);
  localparam int DIV_W    = $clog2(CLK_DIV + 1);
  localparam int WAIT_A   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int WAIT_MAX = (INIT_WAIT > WAIT_A) ? INIT_WAIT : WAIT_A;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_GRANT, S_SETUP, S_SHIFT, S_HOLD, S_DONE
  } state_t;

  state_t                  state_r;
  logic [WAIT_W-1:0]       wait_cnt_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [DIV_W-1:0]        div_cnt_r;
  logic                    phase_hi_r;   // 1 = SCLK high half of the current bit
  logic [SIZESRSTAT-1:0]   shreg_r;
  logic                    grant_dyn_r;  // register owning the current transfer
  logic                    last_dyn_r;   // last grant went to DYN (reset: STAT)

  logic                    req_any_s;
  logic                    pick_dyn_s;
  logic [SIZESRSTAT-1:0]   load_img_s;
  logic [BIT_W-1:0]        last_bit_s;

  // Round-robin choice: a lone requester wins, on contention the one not served last.
  function automatic logic arb_pick_dyn(input logic d_req, input logic s_req, input logic last_dyn);
    arb_pick_dyn = d_req & (~s_req | ~last_dyn);
  endfunction

  // Arbitration, image alignment (dynamic image left-aligned) and frame length.
  always_comb begin
    req_any_s  = dyn_req | stat_req;
    pick_dyn_s = arb_pick_dyn(dyn_req, stat_req, last_dyn_r);
    if (grant_dyn_r) begin
      load_img_s = {dyn_data, {(SIZESRSTAT - SIZESRDYN){1'b0}}};
      last_bit_s = BIT_W'(SIZESRDYN - 1);
    end else begin
      load_img_s = stat_data;
      last_bit_s = BIT_W'(SIZESRSTAT - 1);
    end
  end

  // Sequencer FSM; every output is registered and set for the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_INIT;
      wait_cnt_r  <= '0;
      bit_cnt_r   <= '0;
      div_cnt_r   <= '0;
      phase_hi_r  <= 1'b0;
      shreg_r     <= '0;
      grant_dyn_r <= 1'b0;
      last_dyn_r  <= 1'b0;
      dyn_ack     <= 1'b0;
      stat_ack    <= 1'b0;
      SEL         <= 1'b0;
      MOSI        <= 1'b0;
      SCLK        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      dyn_ack  <= 1'b0;
      stat_ack <= 1'b0;
      done     <= 1'b0;
      case (state_r)
        S_INIT: begin
          if (wait_cnt_r == WAIT_W'(INIT_WAIT - 1)) begin
            wait_cnt_r <= '0;
            state_r    <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        // The DONE cycle also arbitrates so a new ack can follow DONE directly.
        S_IDLE, S_DONE: begin
          SEL <= 1'b0;
          if (start_en && req_any_s) begin
            state_r     <= S_GRANT;
            busy        <= 1'b1;
            grant_dyn_r <= pick_dyn_s;
            last_dyn_r  <= pick_dyn_s;
            dyn_ack     <= pick_dyn_s;
            stat_ack    <= ~pick_dyn_s;
          end else begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        // Ack cycle: the image is captured at its closing edge.
        S_GRANT: begin
          shreg_r    <= load_img_s;
          MOSI       <= load_img_s[SIZESRSTAT-1];
          SEL        <= grant_dyn_r;
          wait_cnt_r <= '0;
          state_r    <= S_SETUP;
        end
        S_SETUP: begin
          if (wait_cnt_r == WAIT_W'(SETUP_CYC - 1)) begin
            wait_cnt_r <= '0;
            bit_cnt_r  <= '0;
            div_cnt_r  <= '0;
            phase_hi_r <= 1'b0;
            state_r    <= S_SHIFT;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        S_SHIFT: begin
          if (div_cnt_r != DIV_W'(CLK_DIV - 1)) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end else if (!phase_hi_r) begin
            div_cnt_r  <= '0;
            phase_hi_r <= 1'b1;
            SCLK       <= 1'b1;
          end else if (bit_cnt_r == last_bit_s) begin
            div_cnt_r  <= '0;
            phase_hi_r <= 1'b0;
            SCLK       <= 1'b0;
            MOSI       <= 1'b0;
            wait_cnt_r <= '0;
            state_r    <= S_HOLD;
          end else begin
            // Next bit starts low; MOSI changes only here, half a bit before the rise.
            div_cnt_r  <= '0;
            phase_hi_r <= 1'b0;
            SCLK       <= 1'b0;
            bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
            shreg_r    <= {shreg_r[SIZESRSTAT-2:0], 1'b0};
            MOSI       <= shreg_r[SIZESRSTAT-2];
          end
        end
        S_HOLD: begin
          if (wait_cnt_r == WAIT_W'(HOLD_CYC - 1)) begin
            wait_cnt_r <= '0;
            SEL        <= 1'b0;
            done       <= 1'b1;
            state_r    <= S_DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          state_r <= S_INIT;
          busy    <= 1'b0;
          SEL     <= 1'b0;
          MOSI    <= 1'b0;
          SCLK    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_prog_scheduler.sv
// Scoreboard bench for sr_prog_scheduler: the driver pushes the expected frame of
// each request; a negedge monitor rebuilds frames from SCLK/MOSI and checks them
// against the queue at every done pulse.
module tb_sr_prog_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start_en = 1'b0;
  logic        dyn_req = 1'b0;
  logic [15:0] dyn_data = 16'h0000;
  logic        stat_req = 1'b0;
  logic [87:0] stat_data = 88'h0;
  logic        dyn_ack, stat_ack, SEL, MOSI, SCLK, busy, done;

  // second instance with CLK_DIV = 1
  logic        dyn_req6 = 1'b0;
  logic [15:0] dyn_data6 = 16'h0000;
  logic        stat_req6 = 1'b0;
  logic [87:0] stat_data6 = 88'h0;
  logic        dyn_ack6, stat_ack6, sel6, mosi6, sclk6, busy6, done6;

  always #5 CLK = ~CLK;

  sr_prog_scheduler dut (
    .CLK(CLK), .RST(RST), .start_en(start_en),
    .dyn_req(dyn_req), .dyn_data(dyn_data), .dyn_ack(dyn_ack),
    .stat_req(stat_req), .stat_data(stat_data), .stat_ack(stat_ack),
    .SEL(SEL), .MOSI(MOSI), .SCLK(SCLK), .busy(busy), .done(done)
  );

  sr_prog_scheduler #(.CLK_DIV(1)) dut6 (
    .CLK(CLK), .RST(RST), .start_en(start_en),
    .dyn_req(dyn_req6), .dyn_data(dyn_data6), .dyn_ack(dyn_ack6),
    .stat_req(stat_req6), .stat_data(stat_data6), .stat_ack(stat_ack6),
    .SEL(sel6), .MOSI(mosi6), .SCLK(sclk6), .busy(busy6), .done(done6)
  );

  typedef struct {
    logic        dyn;
    logic [87:0] data;
    int          nbits;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          ack_cnt = 0;
  int          done_cnt = 0;
  int          ack_cyc = 0;
  int          nbits = 0;
  logic [87:0] frame = 88'h0;
  logic        prev_sclk = 1'b0;
  logic        sel_bad = 1'b0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Hand-derived: DYN 16 bits / 134-cycle transfer, STAT 88 bits / 710-cycle transfer.
  function automatic exp_t mk(input logic dyn, input logic [87:0] data);
    exp_t e;
    e.dyn   = dyn;
    e.data  = data;
    e.nbits = dyn ? 16 : 88;
    e.lat   = dyn ? 133 : 709;
    return e;
  endfunction

  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Monitor: ack ordering, frame capture on SCLK rises, frame check at done.
  always @(negedge CLK) begin
    if (RST) begin
      nbits = 0;
      frame = 88'h0;
      prev_sclk = 1'b0;
      sel_bad = 1'b0;
    end else begin
      if (dyn_ack || stat_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
        nbits = 0;
        frame = 88'h0;
        sel_bad = 1'b0;
        chk("ack exclusive", {87'h0, dyn_ack & stat_ack}, 88'h0);
        if (exp_q.size() > 0) chk("ack type", {87'h0, dyn_ack}, {87'h0, exp_q[0].dyn});
        else chk("unexpected ack", 88'h1, 88'h0);
      end
      if (SCLK && !prev_sclk) begin
        frame = {frame[86:0], MOSI};
        nbits++;
        if (exp_q.size() > 0 && SEL !== exp_q[0].dyn) sel_bad = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame bits", nbits, e.nbits);
          chk("frame data", e.dyn ? {72'h0, frame[15:0]} : frame, e.data);
          chk("latency", cyc - ack_cyc, e.lat);
          chk("SEL during frame", {87'h0, sel_bad}, 88'h0);
          chk("SEL low at done", {87'h0, SEL}, 88'h0);
        end else begin
          chk("unexpected done", 88'h1, 88'h0);
        end
      end
      prev_sclk = SCLK;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input int prev, input int budget, input string name);
    int k = 0;
    while (ack_cnt == prev && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, {87'h0, ack_cnt != prev}, 88'h1);
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int k = 0;
    while (done_cnt == prev && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, {87'h0, done_cnt != prev}, 88'h1);
  endtask

  task automatic wait_bits(input int n, input int budget, input string name);
    int k = 0;
    while (nbits < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, {87'h0, nbits >= n}, 88'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pa, pd;
    int a6, fr6, lr6, rises6, highs6, k;
    logic [15:0] f6;

    // Reset state
    tick(3);
    @(negedge CLK);
    chk("reset outputs", {81'h0, dyn_ack, stat_ack, SEL, MOSI, SCLK, busy, done}, 88'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    start_en = 1'b1;

    // T1: dynamic request raised during INIT
    tick(5);
    dyn_data = 16'hABC6;
    exp_q.push_back(mk(1'b1, 88'hABC6));
    dyn_req = 1'b1;
    pa = ack_cnt; pd = done_cnt;
    wait_ack(pa, 200, "T1 ack");
    chk("T1 no ack before INIT_WAIT", {87'h0, ack_cyc >= 60}, 88'h1);
    dyn_req = 1'b0;
    dyn_data = 16'hFFFF;
    tick(3);
    chk("T1 busy during transfer", {87'h0, busy}, 88'h1);
    wait_done(pd, 300, "T1 done");
    tick(2);
    chk("T1 idle after done", {86'h0, busy, done}, 88'h0);

    // T2: static request
    stat_data = 88'h123456789ABCDEF1234567;
    exp_q.push_back(mk(1'b0, 88'h123456789ABCDEF1234567));
    stat_req = 1'b1;
    pa = ack_cnt; pd = done_cnt;
    wait_ack(pa, 50, "T2 ack");
    stat_req = 1'b0;
    stat_data = 88'h0;
    wait_done(pd, 1000, "T2 done");

    // T3: both requests held, order DYN STAT DYN STAT
    dyn_data = 16'h3C5A;
    stat_data = 88'hF0E1D2C3B4A5968778695A;
    exp_q.push_back(mk(1'b1, 88'h3C5A));
    exp_q.push_back(mk(1'b0, 88'hF0E1D2C3B4A5968778695A));
    exp_q.push_back(mk(1'b1, 88'h3C5A));
    exp_q.push_back(mk(1'b0, 88'hF0E1D2C3B4A5968778695A));
    pd = done_cnt;
    dyn_req = 1'b1;
    stat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pa = ack_cnt;
      wait_ack(pa, 1000, "T3 ack");
    end
    dyn_req = 1'b0;
    stat_req = 1'b0;
    k = 0;
    while (done_cnt < pd + 4 && k < 3000) begin
      tick(1);
      k++;
    end
    chk("T3 four transfers done", done_cnt - pd, 4);

    // T4: disabled with requests pending, then disable mid-transfer
    start_en = 1'b0;
    dyn_req = 1'b1;
    stat_req = 1'b1;
    pa = ack_cnt;
    tick(300);
    chk("T4 no ack while disabled", ack_cnt, pa);
    stat_req = 1'b0;
    dyn_data = 16'h8001;
    exp_q.push_back(mk(1'b1, 88'h8001));
    pd = done_cnt;
    start_en = 1'b1;
    wait_ack(pa, 50, "T4 ack");
    wait_bits(3, 200, "T4 reach bit 3");
    start_en = 1'b0;
    wait_done(pd, 300, "T4 done after disable");
    tick(200);
    chk("T4 no grant after disable", ack_cnt, pa + 1);
    dyn_req = 1'b0;
    start_en = 1'b1;

    // T5: reset in the middle of a static transfer
    stat_data = 88'hA5A5_0000_FFFF_1234_5678_9A;
    exp_q.push_back(mk(1'b0, 88'hA5A5_0000_FFFF_1234_5678_9A));
    stat_req = 1'b1;
    pa = ack_cnt;
    wait_ack(pa, 50, "T5 ack");
    stat_req = 1'b0;
    wait_bits(5, 200, "T5 reach bit 5");
    pd = done_cnt;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("T5 outputs after RST", {83'h0, SCLK, SEL, MOSI, busy, done}, 88'h0);
    exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    dyn_data = 16'h0F0F;
    exp_q.push_back(mk(1'b1, 88'h0F0F));
    dyn_req = 1'b1;
    pa = ack_cnt;
    wait_ack(pa, 200, "T5 ack after reset");
    chk("T5 full INIT_WAIT again", {87'h0, ack_cyc >= 60}, 88'h1);
    chk("T5 no done from aborted frame", done_cnt, pd);
    dyn_req = 1'b0;
    wait_done(pd, 300, "T5 done");

    // T6: CLK_DIV = 1 instance
    dyn_data6 = 16'h5A3C;
    dyn_req6 = 1'b1;
    k = 0;
    a6 = 0;
    while (k < 200) begin
      @(negedge CLK);
      if (dyn_ack6) break;
      k++;
    end
    chk("T6 ack", {87'h0, dyn_ack6}, 88'h1);
    a6 = cyc;
    dyn_req6 = 1'b0;
    fr6 = -1; lr6 = -1; rises6 = 0; highs6 = 0; f6 = 16'h0;
    k = 0;
    while (k < 200) begin
      @(negedge CLK);
      if (done6) break;
      if (sclk6) begin
        highs6++;
        if (rises6 == 0 || lr6 != cyc - 1) begin
          rises6++;
          f6 = {f6[14:0], mosi6};
          if (fr6 < 0) fr6 = cyc;
          if (sel6 !== 1'b1) chk("T6 SEL at rise", 88'h0, 88'h1);
        end
        lr6 = cyc;
      end
      k++;
    end
    chk("T6 done", {87'h0, done6}, 88'h1);
    chk("T6 latency", cyc - a6, 37);
    chk("T6 rises", rises6, 16);
    chk("T6 high cycles", highs6, 16);
    chk("T6 rise span", lr6 - fr6, 30);
    chk("T6 data", {72'h0, f6}, 88'h5A3C);

    tick(5);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
